// File: rtl/piso_serializer_pkg.sv
// serializer_pkg: state encoding and idle line level shared by piso_serializer.
// PAR is always encoded so the state width does not change with PIPO_SERIAL_PARITY_EN.
package serializer_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/piso_serializer_bit_counter.sv
// bit_counter: clearable up-counter with a terminal flag when count equals LAST.
module bit_counter #(
    parameter int WIDTH = 3,
    parameter int LAST = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             tc
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else if (clr) count <= '0;
        else if (inc) count <= count + 1'b1;
    assign tc = count == WIDTH'(LAST);
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready loaded, LSB-first parallel-to-serial transmitter.
// Define PIPO_SERIAL_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic         en,
    output logic         sout,
    output logic         sbusy,
    output logic         done
);
    localparam int CW = $clog2(N) + 1;
    state_t state, state_n;
    logic [N-1:0] shreg;
    logic load, step, tc, done_n;
    bit_counter #(.WIDTH(CW), .LAST(N - 1)) u_cnt (
        .clk(clk), .rst(rst), .clr(load), .inc(step), .count(), .tc(tc)
    );
    assign load = (state == IDLE) && load_valid;
    assign step = (state == SHIFT) && en;
    assign load_ready = state == IDLE;
    assign sbusy = state != IDLE;
`ifdef PIPO_SERIAL_PARITY_EN
    logic par;
    always_ff @(posedge clk or negedge rst)
        if (!rst) par <= 1'b0;
        else if (load) par <= ^d;
    always_comb begin
        state_n = load ? SHIFT : (step && tc) ? PAR : (state == PAR && en) ? IDLE : state;
        done_n = (state == PAR) && en;
        sout = (state == SHIFT) ? shreg[0] : (state == PAR) ? par : IDLE_LEVEL;
    end
`else
    always_comb begin
        state_n = load ? SHIFT : ((step && tc) || state == PAR) ? IDLE : state;
        done_n = step && tc;
        sout = (state == SHIFT) ? shreg[0] : IDLE_LEVEL;
    end
`endif
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            shreg <= '0;
            done <= 1'b0;
        end else begin
            done <= done_n;
            if (load) shreg <= d;
            else if (step) shreg <= shreg >> 1;
        end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed checks of piso_serializer (N=4), inputs driven and outputs sampled on the falling edge.
module tb_piso_serializer;
`ifdef PIPO_SERIAL_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    logic clk, rst, load_valid, load_ready, en, sout, sbusy, done;
    logic [3:0] d;
    int errors = 0;
    int checks = 0;

    piso_serializer #(.N(4)) dut (
        .clk(clk), .rst(rst), .d(d), .load_valid(load_valid), .load_ready(load_ready),
        .en(en), .sout(sout), .sbusy(sbusy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic expb(input logic [3:0] v, input int i);
        return (i < 4) ? v[i] : ^v;
    endfunction

    task automatic test_reset();
        rst = 1'b0; load_valid = 1'b1; d = 4'hF; en = 1'b1;
        repeat (3) @(negedge clk);
        checks += 4;
        if (sout !== 1'b1) begin errors++; $display("FAIL reset_sout got=%b exp=1", sout); end
        if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
        if (sbusy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", sbusy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        load_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 2;
        if (sbusy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", sbusy); end
        if (sout !== 1'b1) begin errors++; $display("FAIL post_reset_sout got=%b exp=1", sout); end
    endtask

    task automatic test_basic(input logic [3:0] v);
        d = v; load_valid = 1'b1; en = 1'b1;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            checks += 3;
            if (sout !== expb(v, i)) begin errors++; $display("FAIL basic_%h_bit%0d got=%b exp=%b", v, i, sout, expb(v, i)); end
            if (sbusy !== 1'b1) begin errors++; $display("FAIL basic_%h_busy%0d got=%b exp=1", v, i, sbusy); end
            if (done !== 1'b0) begin errors++; $display("FAIL basic_%h_early_done%0d got=%b exp=0", v, i, done); end
        end
        @(negedge clk);
        checks += 3;
        if (done !== 1'b1) begin errors++; $display("FAIL basic_%h_done got=%b exp=1", v, done); end
        if (sout !== 1'b1) begin errors++; $display("FAIL basic_%h_done_sout got=%b exp=1", v, sout); end
        if (load_ready !== 1'b1) begin errors++; $display("FAIL basic_%h_done_ready got=%b exp=1", v, load_ready); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_%h_done_clear got=%b exp=0", v, done); end
    endtask

    task automatic test_stall();
        logic [5:0] seq;
        seq = 6'b001111;
        d = 4'h3; load_valid = 1'b1; en = 1'b1;
        for (int k = 0; k < NB + 2; k++) begin
            @(negedge clk);
            load_valid = 1'b0;
            checks += 2;
            if (k < 6 && sout !== seq[k]) begin errors++; $display("FAIL stall_bit%0d got=%b exp=%b", k, sout, seq[k]); end
            if (k >= 6 && sout !== 1'b0) begin errors++; $display("FAIL stall_par got=%b exp=0", sout); end
            if (done !== 1'b0) begin errors++; $display("FAIL stall_early_done%0d got=%b exp=0", k, done); end
            en = !(k == 1 || k == 2);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL stall_done got=%b exp=1", done); end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL stall_done_clear got=%b exp=0", done); end
        en = 1'b1;
    endtask

    task automatic test_back_to_back();
        d = 4'hA; load_valid = 1'b1; en = 1'b1;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            load_valid = (i == 1);
            if (i == 1) d = 4'h6;
            checks++;
            if (sout !== expb(4'hA, i)) begin errors++; $display("FAIL busyload_bit%0d got=%b exp=%b", i, sout, expb(4'hA, i)); end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL busyload_done got=%b exp=1", done); end
        d = 4'h6; load_valid = 1'b1;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            load_valid = 1'b0;
            checks += 3;
            if (sout !== expb(4'h6, i)) begin errors++; $display("FAIL b2b_bit%0d got=%b exp=%b", i, sout, expb(4'h6, i)); end
            if (sbusy !== 1'b1) begin errors++; $display("FAIL b2b_busy%0d got=%b exp=1", i, sbusy); end
            if (done !== 1'b0) begin errors++; $display("FAIL b2b_extra_done%0d got=%b exp=0", i, done); end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%b exp=1", done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        d = 4'hA; load_valid = 1'b1; en = 1'b1;
        repeat (2) @(negedge clk);
        load_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks += 3;
        if (sout !== 1'b1) begin errors++; $display("FAIL midreset_sout got=%b exp=1", sout); end
        if (sbusy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", sbusy); end
        if (load_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", load_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b1;
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL midreset_done%0d got=%b exp=0", i, done); end
        end
        test_basic(4'h5);
    endtask

    task automatic test_idle_en_low();
        d = 4'h9; load_valid = 1'b1; en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            load_valid = 1'b0;
            checks += 2;
            if (sbusy !== 1'b1) begin errors++; $display("FAIL enlow_load_busy got=%b exp=1", sbusy); end
            if (sout !== 1'b1) begin errors++; $display("FAIL enlow_hold_bit0 got=%b exp=1", sout); end
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (sout !== 1'b0) begin errors++; $display("FAIL enlow_bit1 got=%b exp=0", sout); end
        repeat (NB) @(negedge clk);
        checks++;
        if (sbusy !== 1'b0) begin errors++; $display("FAIL enlow_end_busy got=%b exp=0", sbusy); end
    endtask

`ifdef PIPO_SERIAL_PARITY_EN
    task automatic test_parity_hold();
        d = 4'h7; load_valid = 1'b1; en = 1'b1;
        repeat (4) begin
            @(negedge clk);
            load_valid = 1'b0;
        end
        @(negedge clk);
        en = 1'b0;
        repeat (3) begin
            checks += 3;
            if (sout !== 1'b1) begin errors++; $display("FAIL par_hold_sout got=%b exp=1", sout); end
            if (sbusy !== 1'b1) begin errors++; $display("FAIL par_hold_busy got=%b exp=1", sbusy); end
            if (done !== 1'b0) begin errors++; $display("FAIL par_hold_done got=%b exp=0", done); end
            @(negedge clk);
        end
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL par_hold_final_done got=%b exp=1", done); end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b0; load_valid = 1'b0; en = 1'b0; d = 4'h0;
        test_reset();
        test_basic(4'hA);
        test_basic(4'h7);
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_idle_en_low();
`ifdef PIPO_SERIAL_PARITY_EN
        test_parity_hold();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter that is the outbound counterpart of the team's parallel holding register.
- Accepts an N-bit word through a valid/ready load handshake and shifts it out LSB-first on a single line, one bit per enabled clock.
- Sits between register-file/datapath outputs and any bit-serial link.
- Reports busy status and a one-cycle completion pulse.

Parameters:
- N, 4, data word width in bits; legal range N >= 1.

Ports:
- clk        input   1  system clock; all state changes on the rising edge.
- rst        input   1  asynchronous, active-low reset.
- d          input   N  parallel word to transmit.
- load_valid input   1  producer offers d this cycle.
- load_ready output  1  serializer can accept a word (high only in IDLE).
- en         input   1  shift enable / bit tick; when low, frame state holds.
- sout       output  1  serial data out; idle level is 1.
- sbusy      output  1  high while a frame is in progress.
- done       output  1  one-cycle pulse after the last frame bit.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low.
- Reset (rst=0, asynchronous, any state): state=IDLE, shift register=0, bit counter=0, sout=1, sbusy=0, done=0, load_ready=1.
- Bit counter width: $clog2(N)+1.
- All outputs are registered or decoded from state, so there are no combinational paths from inputs to outputs.
- States: IDLE, SHIFT, plus PAR under PARITY_EN.
- IDLE:
  - load_ready=1, sbusy=0, sout=1.
  - Transfer happens on a rising edge with load_valid && load_ready: capture d, counter=0, go to SHIFT.
  - en is ignored in IDLE; loads are accepted even with en=0.
- SHIFT:
  - load_ready=0, sbusy=1, sout=shreg[0].
  - Rising edge with en=1: shift right by one, counter+1.
  - Rising edge with en=0: hold everything; the current bit stays on sout.
  - When en=1 and counter==N-1: go to IDLE (or PAR if enabled); done=1 for exactly the next cycle.
- Latency with en tied high: bit0 appears on sout the cycle after the load edge; N cycles per frame; done is high in cycle N+1, together with sout=1 and load_ready=1.
- Back-to-back frames: a load in the done cycle is legal and gives zero idle bits between frames.
- load_valid asserted while sbusy=1 is ignored. No capture; the in-flight frame is unaffected.
- Reset asserted mid-frame aborts the frame immediately, with no done pulse. After release, the block is in IDLE.
- done is never asserted except on frame completion. It deasserts the following cycle regardless of en.

Optional Feature:
- Macro: PIPO_SERIAL_PARITY_EN.
- Defined:
  - After the last data bit, the block enters PAR for one en-qualified bit time.
  - sout = even parity (XOR) of the word captured at load; the parity is computed at load and stored in a 1-bit register.
  - Frame length is N+1; done follows the PAR bit; en=0 holds PAR.
- Undefined: PAR state and the parity register are absent; frame length is N.

Decomposition:
- Package serializer_pkg:
  - state_t enum {IDLE, SHIFT, PAR}, 2 bits; PAR is always encoded, even when unused.
  - Constant IDLE_LEVEL = 1'b1.
- Sub-module bit_counter:
  - Parameterised width.
  - Inputs clk, rst, clr, inc.
  - Outputs count and terminal flag tc (count==LAST).
  - Same async active-low reset.

Test Plan:
- Reset: hold rst=0 with load_valid=1 and d=4'hF -> sout=1, load_ready=1, sbusy=0, done=0; nothing captured. Release rst -> still IDLE.
- Basic frame (N=4, en=1): load d=4'hA -> sout 0,1,0,1 on the 4 cycles after the load edge, sbusy=1 throughout; cycle 5: done=1, sout=1, load_ready=1; cycle 6: done=0.
- Enable stall: load 4'h3, drop en for 2 cycles after bit0 is shifted -> sout shows 1,1,1,1,0,0 (bit1 held 3 cycles); frame spans 6 cycles, followed by a single done.
- Busy-load ignore: during a 4'hA frame, pulse load_valid with d=4'h6 -> output remains 0,1,0,1, single done. Then back-to-back load of 4'h6 in the done cycle -> 0,1,1,0 with no idle gap.
- Reset mid-frame: load 4'hA, assert rst after 2 bits -> sout=1 and sbusy=0 immediately, no done. After release, load 4'h5 -> 1,0,1,0, then done.
- With PIPO_SERIAL_PARITY_EN: d=4'hA -> 0,1,0,1,0 then done; d=4'h7 -> 1,1,1,0,1 then done; en=0 during the PAR bit holds it.
